// File: rtl/fb_scheduler.sv
// Filterbank job sequencer: walks (channel, stage) jobs through a shared biquad engine
// once per input sample, with one-deep sample buffering, job timeout and sticky error flags.
module fb_scheduler #(
    parameter int N_FILTERS = 16,
    parameter int TIMEOUT   = 63
) (
    input  logic                         clk_in,
    input  logic                         n_rst_in,
    input  logic                         sample_valid_in,
    input  logic                         done_in,
    input  logic                         clear_in,
    output logic                         start_out,
    output logic [$clog2(N_FILTERS)-1:0] chan_out,
    output logic [1:0]                   stage_out,
    output logic                         result_we_out,
    output logic                         busy_out,
    output logic                         frame_done_out,
    output logic                         overrun_out,
    output logic                         timeout_out
);

    // state  | meaning
    // IDLE   | no frame in progress
    // ISSUE  | start pulse out for current (chan, stage)
    // WAIT   | engine running, timeout counter active
    // WRITE  | result strobe for current job
    // NEXT   | advance job order, end-of-frame handling
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_NEXT
    } state_t;

    localparam int CW = $clog2(N_FILTERS);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_CHAN = CW'(N_FILTERS - 1);
    localparam logic [TW-1:0] CNT_LOAD  = TW'(TIMEOUT - 1);

    state_t          r_state;
    logic            r_pending;
    logic [TW-1:0]   r_wait_cnt;
    logic            r_start;
    logic [CW-1:0]   r_chan;
    logic [1:0]      r_stage;
    logic            r_we;
    logic            r_busy;
    logic            r_frame_done;
    logic            r_overrun;
    logic            r_timeout;

    logic            w_last;
    logic            w_ov_set;
    logic            w_to_set;

    assign w_last   = (r_chan == LAST_CHAN) && (r_stage == 2'd2);
    assign w_ov_set = sample_valid_in && r_busy && r_pending;
    assign w_to_set = (r_state == S_WAIT) && !done_in && (r_wait_cnt == '0);

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            r_state      <= S_IDLE;
            r_pending    <= 1'b0;
            r_wait_cnt   <= '0;
            r_start      <= 1'b0;
            r_chan       <= '0;
            r_stage      <= 2'd0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_start      <= 1'b0;
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= w_ov_set | (r_overrun & ~clear_in);
            r_timeout    <= w_to_set | (r_timeout & ~clear_in);

            // A sample landing on the final NEXT starts the next frame directly instead.
            if (sample_valid_in && r_busy && !r_pending && !((r_state == S_NEXT) && w_last))
                r_pending <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (sample_valid_in) begin
                        r_state <= S_ISSUE;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_chan  <= '0;
                        r_stage <= 2'd0;
                    end
                end
                S_ISSUE: begin
                    r_state    <= S_WAIT;
                    r_wait_cnt <= CNT_LOAD;
                end
                S_WAIT: begin
                    if (done_in) begin
                        r_state <= S_WRITE;
                        r_we    <= 1'b1;
                    end else if (r_wait_cnt == '0) begin
                        r_state      <= S_NEXT;
                        r_frame_done <= w_last;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                S_WRITE: begin
                    r_state      <= S_NEXT;
                    r_frame_done <= w_last;
                end
                S_NEXT: begin
                    if (!w_last) begin
                        if (r_stage == 2'd2) begin
                            r_stage <= 2'd0;
                            r_chan  <= r_chan + 1'b1;
                        end else begin
                            r_stage <= r_stage + 2'd1;
                        end
                        r_state <= S_ISSUE;
                        r_start <= 1'b1;
                    end else begin
                        r_chan  <= '0;
                        r_stage <= 2'd0;
                        if (r_pending || sample_valid_in) begin
                            r_state   <= S_ISSUE;
                            r_start   <= 1'b1;
                            r_pending <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign start_out      = r_start;
    assign chan_out       = r_chan;
    assign stage_out      = r_stage;
    assign result_we_out  = r_we;
    assign busy_out       = r_busy;
    assign frame_done_out = r_frame_done;
    assign overrun_out    = r_overrun;
    assign timeout_out    = r_timeout;

endmodule

// File: tb/tb_fb_scheduler.sv
// Bench for fb_scheduler: engine responder with programmable latency, event trace recorder,
// and a schedule model built from job durations (D+3 per answered job, TIMEOUT+2 per abandoned one).
module tb_fb_scheduler;

    localparam int NF = 4;
    localparam int TO = 63;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sv = 1'b0;
    logic       done = 1'b0;
    logic       clr = 1'b0;
    logic       start_out;
    logic [1:0] chan_out;
    logic [1:0] stage_out;
    logic       result_we_out;
    logic       busy_out;
    logic       frame_done_out;
    logic       overrun_out;
    logic       timeout_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int D = 2;
    int skip_c = -1;
    int skip_s = -1;
    int resp_cnt = 0;
    int obs[$];
    int exp_q[$];

    fb_scheduler #(.N_FILTERS(NF), .TIMEOUT(TO)) u_dut (
        .clk_in         (clk),
        .n_rst_in       (rst_n),
        .sample_valid_in(sv),
        .done_in        (done),
        .clear_in       (clr),
        .start_out      (start_out),
        .chan_out       (chan_out),
        .stage_out      (stage_out),
        .result_we_out  (result_we_out),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out),
        .overrun_out    (overrun_out),
        .timeout_out    (timeout_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Engine: answers D cycles after each start pulse unless the job is the one to ignore.
    always @(negedge clk) begin
        done = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) done = 1'b1;
        end
        if (start_out && !(int'(chan_out) == skip_c && int'(stage_out) == skip_s))
            resp_cnt = D;
    end

    // Event code: time*256 + kind*16 + chan*4 + stage (kind 1 start, 2 write, 3 frame done)
    always @(negedge clk) begin
        if (rst_n) begin
            if (start_out)      obs.push_back(cyc * 256 + 16 + int'(chan_out) * 4 + int'(stage_out));
            if (result_we_out)  obs.push_back(cyc * 256 + 32 + int'(chan_out) * 4 + int'(stage_out));
            if (frame_done_out) obs.push_back(cyc * 256 + 48);
        end
    end

    function automatic string fmt(input int v);
        return $sformatf("t%0d/k%0d/c%0d/s%0d", v / 256, (v % 256) / 16, (v % 16) / 4, v % 4);
    endfunction

    // Reference schedule: jobs in order (c,s) = (j/3, j%3); job idx 'skip' of the first frame is never answered.
    task automatic gen_expect(input int t0, input int nfr, input int skip, input int d, output int t_end);
        int t;
        int dur;
        exp_q.delete();
        t = t0 + 1;
        for (int f = 0; f < nfr; f++) begin
            for (int j = 0; j < 3 * NF; j++) begin
                exp_q.push_back(t * 256 + 16 + (j / 3) * 4 + (j % 3));
                if (f == 0 && j == skip) begin
                    dur = TO + 2;
                end else begin
                    dur = d + 3;
                    exp_q.push_back((t + d + 1) * 256 + 32 + (j / 3) * 4 + (j % 3));
                end
                if (j == 3 * NF - 1) exp_q.push_back((t + dur - 1) * 256 + 48);
                t += dur;
            end
        end
        t_end = t - 1;
    endtask

    task automatic do_reset();
        sv = 1'b0;
        clr = 1'b0;
        skip_c = -1;
        skip_s = -1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({start_out, chan_out, stage_out, result_we_out, busy_out, frame_done_out, overrun_out, timeout_out} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs actual=%b required=0", {start_out, chan_out, stage_out, result_we_out, busy_out, frame_done_out, overrun_out, timeout_out});
        end
        do_reset();
        repeat (5) @(negedge clk);
        checks++;
        if (obs.size() != 0 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle actual=events%0d/busy%b required=events0/busy0", obs.size(), busy_out);
        end
    endtask

    task automatic test_basic(input int d);
        int t0, te;
        do_reset();
        D = d;
        t0 = cyc;
        gen_expect(t0, 1, -1, d, te);
        for (int k = 0; k <= te - t0 + 3; k++) begin
            if (k == te - t0 + 1) begin
                checks++;
                if (busy_out !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_busy_end d=%0d actual=%b required=0", d, busy_out);
                end
            end
            sv = (k == 0);
            @(negedge clk);
        end
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_trace_len d=%0d actual=%0d required=%0d", d, obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_event%0d d=%0d actual=%s required=%s", i, d, fmt(obs[i] - t0 * 256), fmt(exp_q[i] - t0 * 256));
            end
        end
        checks++;
        if ({overrun_out, timeout_out} !== 2'b00) begin
            errors++;
            $display("FAIL basic_flags d=%0d actual=%b required=00", d, {overrun_out, timeout_out});
        end
    endtask

    task automatic test_pending(input int d, input bit rnd);
        int t0, te, len, s1;
        do_reset();
        D = d;
        len = 3 * NF * (d + 3);
        s1 = rnd ? $urandom_range(len - 1, 2) : 20;
        t0 = cyc;
        gen_expect(t0, 2, -1, d, te);
        for (int k = 0; k <= te - t0 + 3; k++) begin
            if (k == len + 1) begin
                checks++;
                if (busy_out !== 1'b1) begin
                    errors++;
                    $display("FAIL pending_busy_gap d=%0d s=%0d actual=%b required=1", d, s1, busy_out);
                end
            end
            sv = (k == 0 || k == s1);
            @(negedge clk);
        end
        checks++;
        if (overrun_out !== 1'b0 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL pending_end d=%0d s=%0d actual=ov%b/busy%b required=ov0/busy0", d, s1, overrun_out, busy_out);
        end
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL pending_trace_len d=%0d actual=%0d required=%0d", d, obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL pending_event%0d d=%0d actual=%s required=%s", i, d, fmt(obs[i] - t0 * 256), fmt(exp_q[i] - t0 * 256));
            end
        end
    endtask

    task automatic test_overrun(input int d, input bit rnd);
        int t0, te, len, s1, s2;
        do_reset();
        D = d;
        len = 3 * NF * (d + 3);
        s1 = rnd ? $urandom_range(len - 2, 2) : 20;
        s2 = rnd ? $urandom_range(len - 1, s1 + 1) : 30;
        t0 = cyc;
        gen_expect(t0, 2, -1, d, te);
        for (int k = 0; k <= te - t0 + 3; k++) begin
            if (k == s2 || k == s2 + 1) begin
                checks++;
                if (overrun_out !== (k == s2 + 1)) begin
                    errors++;
                    $display("FAIL overrun_edge d=%0d rel=%0d actual=%b required=%b", d, k - s2, overrun_out, k == s2 + 1);
                end
            end
            sv = (k == 0 || k == s1 || k == s2);
            @(negedge clk);
        end
        checks++;
        if (overrun_out !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky d=%0d actual=%b required=1", d, overrun_out);
        end
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL overrun_trace_len d=%0d actual=%0d required=%0d", d, obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL overrun_event%0d d=%0d actual=%s required=%s", i, d, fmt(obs[i] - t0 * 256), fmt(exp_q[i] - t0 * 256));
            end
        end
    endtask

    task automatic test_timeout(input int d);
        int t0, te, xp, nwr;
        do_reset();
        D = d;
        skip_c = 1;
        skip_s = 1;
        xp = 1 + 4 * (d + 3) + TO;
        t0 = cyc;
        gen_expect(t0, 1, 4, d, te);
        for (int k = 0; k <= te - t0 + 3; k++) begin
            if (k >= xp && k <= xp + 2) begin
                checks++;
                if (timeout_out !== (k == xp + 1)) begin
                    errors++;
                    $display("FAIL timeout_clear_prio d=%0d rel=%0d actual=%b required=%b", d, k - xp, timeout_out, k == xp + 1);
                end
            end
            sv = (k == 0);
            clr = (k == xp || k == xp + 1);
            @(negedge clk);
        end
        clr = 1'b0;
        nwr = 0;
        foreach (obs[i]) if ((obs[i] % 256) / 16 == 2) nwr++;
        checks++;
        if (nwr != 3 * NF - 1) begin
            errors++;
            $display("FAIL timeout_writes d=%0d actual=%0d required=%0d", d, nwr, 3 * NF - 1);
        end
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL timeout_trace_len d=%0d actual=%0d required=%0d", d, obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL timeout_event%0d d=%0d actual=%s required=%s", i, d, fmt(obs[i] - t0 * 256), fmt(exp_q[i] - t0 * 256));
            end
        end
    endtask

    task automatic test_reset_mid(input int d);
        int t0, te, kr, t1;
        int keep[$];
        do_reset();
        D = d;
        kr = 1 + 6 * (d + 3) + 1;
        t0 = cyc;
        gen_expect(t0, 1, -1, d, te);
        foreach (exp_q[i]) if (exp_q[i] / 256 < t0 + kr) keep.push_back(exp_q[i]);
        for (int k = 0; k < kr; k++) begin
            sv = (k == 0);
            @(negedge clk);
        end
        sv = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({start_out, chan_out, stage_out, result_we_out, busy_out, frame_done_out, overrun_out, timeout_out} !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid_async actual=%b required=0", {start_out, chan_out, stage_out, result_we_out, busy_out, frame_done_out, overrun_out, timeout_out});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (obs.size() != keep.size() || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet actual=events%0d/busy%b required=events%0d/busy0", obs.size(), busy_out, keep.size());
        end
        for (int i = 0; i < obs.size() && i < keep.size(); i++) begin
            checks++;
            if (obs[i] !== keep[i]) begin
                errors++;
                $display("FAIL reset_mid_event%0d actual=%s required=%s", i, fmt(obs[i] - t0 * 256), fmt(keep[i] - t0 * 256));
            end
        end
        obs.delete();
        t1 = cyc;
        gen_expect(t1, 1, -1, d, te);
        for (int k = 0; k <= te - t1 + 2; k++) begin
            sv = (k == 0);
            @(negedge clk);
        end
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_mid_restart_len actual=%0d required=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_mid_restart%0d actual=%s required=%s", i, fmt(obs[i] - t1 * 256), fmt(exp_q[i] - t1 * 256));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(2);
        test_basic($urandom_range(6, 1));
        test_basic($urandom_range(6, 1));
        test_pending(2, 1'b0);
        test_pending($urandom_range(5, 1), 1'b1);
        test_overrun(2, 1'b0);
        test_overrun($urandom_range(5, 1), 1'b1);
        test_timeout(2);
        test_timeout($urandom_range(5, 1));
        test_reset_mid(2);
        test_reset_mid($urandom_range(5, 1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
